hast_axi_lite_reg_slave: RTL and testbench

//  AXI4-Lite responder (slave) for the Hast_IP register window; the endpoint that the master BFM/PS drives.

---
 rtl/hast_axi_pkg.sv | 45 ++++
 rtl/hast_axi_lite_wr_capture.sv | 62 ++++++
 rtl/hast_axi_lite_reg_slave.sv | 248 ++++++++++++++++++++++++
 tb/tb_hast_axi_lite_reg_slave.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hast_axi_pkg.sv
// -----------------------------------------------------------------------------
// hast_axi_pkg
// Shared definitions for the Hast_IP AXI4-Lite register window:
//   - AXI response encodings
//   - byte-address to word-index shift (AXI_LITE_ADDR_LSB)
//   - write / read FSM state types
//   - apply_wstrb(): byte-strobe merge of new write data into an old word
// -----------------------------------------------------------------------------
package hast_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int AXI_LITE_ADDR_LSB = 2;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // Replace each byte of old_w whose strobe bit is set with the matching byte of new_w.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_w[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_w[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hast_axi_lite_wr_capture.sv
// -----------------------------------------------------------------------------
// hast_axi_lite_wr_capture
// Holds one beat of an AXI channel (AW or W). The beat is accepted when
// valid_i is seen with ready_o high; it stays held until release_i.
// ready_o is registered as the inverse of the next held flag, so it is low
// during reset and rises the first cycle after reset is released.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   valid_i, data_i    channel VALID and payload
//   release_i          drop the held beat
//   ready_o            channel READY
//   held_o, data_o     held flag and captured payload
// -----------------------------------------------------------------------------
module hast_axi_lite_wr_capture #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         release_i,
  output logic         ready_o,
  output logic         held_o,
  output logic [W-1:0] data_o
);

  logic         held_q, held_d;
  logic         ready_q;
  logic [W-1:0] data_q, data_d;

  // Next-state of the held beat: release has priority over a new capture.
  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (release_i) begin
      held_d = 1'b0;
    end else if (valid_i && ready_q) begin
      held_d = 1'b1;
      data_d = data_i;
    end else begin
      held_d = held_q;
    end
  end

  // Capture registers and registered READY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      held_q  <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      held_q  <= held_d;
      data_q  <= data_d;
      ready_q <= ~held_d;
    end
  end

  assign ready_o = ready_q;
  assign held_o  = held_q;
  assign data_o  = data_q;

endmodule

// File: rtl/hast_axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// hast_axi_lite_reg_slave
// AXI4-Lite responder for the Hast_IP register window. NUM_REGS 32-bit RW
// registers with byte strobes, one outstanding write and one outstanding read
// on independent paths. Every READY/VALID/response output is registered.
// Ports:
//   ACLK, ARESET               clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*            write address, data and response channels
//   S_AXI_AR*/R*               read address and data channels
//   reg_q                      register contents, reg i at [i*32 +: 32]
//   reg_wr_pulse               one-cycle pulse per register write commit
// Configuration macro: HAST_AXI_LITE_ADDR_CHECK_EN
//   defined   - out-of-range accesses answer SLVERR (no write, read data 0)
//   undefined - index wraps modulo NUM_REGS, every response is OKAY
// -----------------------------------------------------------------------------
module hast_axi_lite_reg_slave
  import hast_axi_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;

  // Register file and write-path state
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  wr_state_e         wr_state_q, wr_state_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic              wr_release_s;

  // Read-path state
  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  // Capture outputs
  logic                     aw_ready_s, aw_held_s;
  logic [ADDR_W-1:0]        aw_addr_s;
  logic                     w_ready_s, w_held_s;
  logic [STRB_W+DATA_W-1:0] w_beat_s;
  logic [DATA_W-1:0]        w_data_s;
  logic [STRB_W-1:0]        w_strb_s;

  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic             unused_s;

  hast_axi_lite_wr_capture #(.W(ADDR_W)) u_aw_cap (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .valid_i   (S_AXI_AWVALID),
    .data_i    (S_AXI_AWADDR),
    .release_i (wr_release_s),
    .ready_o   (aw_ready_s),
    .held_o    (aw_held_s),
    .data_o    (aw_addr_s)
  );

  hast_axi_lite_wr_capture #(.W(STRB_W + DATA_W)) u_w_cap (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .valid_i   (S_AXI_WVALID),
    .data_i    ({S_AXI_WSTRB, S_AXI_WDATA}),
    .release_i (wr_release_s),
    .ready_o   (w_ready_s),
    .held_o    (w_held_s),
    .data_o    (w_beat_s)
  );

  assign w_data_s = w_beat_s[DATA_W-1:0];
  assign w_strb_s = w_beat_s[STRB_W+DATA_W-1:DATA_W];

  // Word index from the byte address; ADDR[1:0] never matters.
  assign wr_idx_s = aw_addr_s[AXI_LITE_ADDR_LSB +: IDX_W];
  assign rd_idx_s = S_AXI_ARADDR[AXI_LITE_ADDR_LSB +: IDX_W];

`ifdef HAST_AXI_LITE_ADDR_CHECK_EN
  // NUM_REGS is a power of two, so "word address < NUM_REGS" means all bits above the index are zero.
  assign wr_ok_s = (aw_addr_s[ADDR_W-1:AXI_LITE_ADDR_LSB+IDX_W] == '0);
  assign rd_ok_s = (S_AXI_ARADDR[ADDR_W-1:AXI_LITE_ADDR_LSB+IDX_W] == '0);
`else
  assign wr_ok_s = 1'b1;
  assign rd_ok_s = 1'b1;
`endif

  // PROT and the address bits outside the decode carry no meaning here.
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR, aw_addr_s};

  // Write FSM: wait for both beats, commit for one cycle, then hold B until BREADY.
  always_comb begin
    wr_state_d   = wr_state_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    wr_pulse_d   = '0;
    wr_release_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    case (wr_state_q)
      W_IDLE: begin
        if (aw_held_s && w_held_s) begin
          wr_state_d = W_COMMIT;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_COMMIT: begin
        if (wr_ok_s) begin
          regs_d[wr_idx_s]     = apply_wstrb(regs_q[wr_idx_s], w_data_s, w_strb_s);
          wr_pulse_d[wr_idx_s] = 1'b1;
          bresp_d              = RESP_OKAY;
        end else begin
          bresp_d = RESP_SLVERR;
        end
        bvalid_d   = 1'b1;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d     = 1'b0;
          wr_release_s = 1'b1;
          wr_state_d   = W_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        bvalid_d   = 1'b0;
        wr_state_d = W_IDLE;
      end
    endcase
  end

  // Read FSM: the AR handshake samples the register file before any same-edge commit.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rdata_d    = rd_ok_s ? regs_q[rd_idx_s] : '0;
          rresp_d    = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = R_RESP;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end else begin
          arready_d = 1'b0;
        end
      end
      default: begin
        rvalid_d   = 1'b0;
        arready_d  = 1'b0;
        rd_state_d = R_IDLE;
      end
    endcase
  end

  // State and output registers for both paths.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wr_state_q <= wr_state_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign S_AXI_AWREADY = aw_ready_s;
  assign S_AXI_WREADY  = w_ready_s;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_pulse  = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_hast_axi_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_hast_axi_lite_reg_slave
// Directed bench for hast_axi_lite_reg_slave (NUM_REGS=4). Inputs change and
// outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_hast_axi_lite_reg_slave;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [31:0]  S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [31:0]  S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  int errors = 0;
  int checks = 0;
  int pulse_cnt [4] = '{0, 0, 0, 0};

  logic [1:0]  resp;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  int          p1_before;

  always #5 ACLK = ~ACLK;

  hast_axi_lite_reg_slave #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(4)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_q         (reg_q),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  // Count write pulses per register, one sample per cycle.
  always @(negedge ACLK) begin
    for (int i = 0; i < 4; i++) begin
      if (reg_wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] reg_word(input int idx);
    return reg_q[idx*32 +: 32];
  endfunction

  // Present AW and W together and wait until both handshakes have happened.
  task automatic wr_issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_hs, w_hs;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 20 && (S_AXI_AWVALID || S_AXI_WVALID); i++) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_hs) S_AXI_AWVALID = 1'b0;
      if (w_hs)  S_AXI_WVALID  = 1'b0;
    end
    check_eq("wr_issue_done", {30'd0, S_AXI_AWVALID, S_AXI_WVALID}, 32'd0);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
  endtask

  // Accept the write response (bounded wait).
  task automatic wr_resp(output logic [1:0] r);
    logic done;
    done = 1'b0;
    r = 2'bxx;
    S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (S_AXI_BVALID) begin
        r = S_AXI_BRESP;
        done = 1'b1;
      end
      tick();
    end
    S_AXI_BREADY = 1'b0;
    check_eq("b_done", {31'd0, done}, 32'd1);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] r);
    wr_issue(addr, data, strb);
    wr_resp(r);
  endtask

  // Full read; also checks RVALID follows the AR handshake by one edge.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic hs, done;
    hs = 1'b0;
    done = 1'b0;
    d = 32'hxxxxxxxx;
    r = 2'bxx;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = S_AXI_ARREADY;
      tick();
    end
    S_AXI_ARVALID = 1'b0;
    check_eq("ar_done", {31'd0, hs}, 32'd1);
    check_eq("rvalid_lat", {31'd0, S_AXI_RVALID}, 32'd1);
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (S_AXI_RVALID) begin
        d = S_AXI_RDATA;
        r = S_AXI_RRESP;
        done = 1'b1;
      end
      tick();
    end
    S_AXI_RREADY = 1'b0;
    check_eq("r_done", {31'd0, done}, 32'd1);
  endtask

  // W presented `lead` cycles before AW (0 = same cycle); checks the 2-edge commit latency.
  task automatic wr_lead(input logic [31:0] addr, input logic [31:0] data, input int lead);
    int idx;
    idx = int'(addr[3:2]);
    check_eq("lead_wready_pre", {31'd0, S_AXI_WREADY}, 32'd1);
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    if (lead == 0) S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    if (lead > 0) begin
      check_eq("lead_w_held", {31'd0, S_AXI_WREADY}, 32'd0);
      check_eq("lead_aw_ready", {31'd0, S_AXI_AWREADY}, 32'd1);
      repeat (lead - 1) tick();
      S_AXI_AWVALID = 1'b1;
      tick();
    end
    S_AXI_AWVALID = 1'b0;
    check_eq("lead_bvalid_e1", {31'd0, S_AXI_BVALID}, 32'd0);
    tick();
    check_eq("lead_bvalid_e2", {31'd0, S_AXI_BVALID}, 32'd0);
    tick();
    check_eq("lead_bvalid_e3", {31'd0, S_AXI_BVALID}, 32'd1);
    check_eq("lead_reg", reg_word(idx), data);
    check_eq("lead_pulse", {28'd0, reg_wr_pulse}, 32'd1 << idx);
    wr_resp(resp);
    check_eq("lead_bresp", {30'd0, resp}, 32'd0);
  endtask

  initial begin
    logic [31:0] wdat [4];
    wdat[0] = 32'h0101FFFF;
    wdat[1] = 32'hABCD0001;
    wdat[2] = 32'hDEAD0011;
    wdat[3] = 32'hBEEF0011;

    ARESET = 1'b1;
    S_AXI_AWADDR = 32'd0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = 32'd0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_readys", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
    check_eq("rst_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
    check_eq("rst_resp_rdata", {S_AXI_RDATA[27:0], S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    check_eq("rst_regs", {31'd0, (reg_q != 128'd0)}, 32'd0);
    check_eq("rst_pulse", {28'd0, reg_wr_pulse}, 32'd0);
    ARESET = 1'b0;
    tick();
    check_eq("post_rst_readys", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);

    // Test 1: write all four registers, read them back
    for (int i = 0; i < 4; i++) begin
      axi_write(32'(i * 4), wdat[i], 4'hF, resp);
      check_eq("t1_bresp", {30'd0, resp}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(i * 4), rdata, rresp);
      check_eq("t1_rdata", rdata, wdat[i]);
      check_eq("t1_rresp", {30'd0, rresp}, 32'd0);
      check_eq("t1_reg_q", reg_word(i), wdat[i]);
    end

    // Test 2: byte strobes and pulse count on reg1
    p1_before = pulse_cnt[1];
    axi_write(32'h4, 32'hFFFFFFFF, 4'hF, resp);
    axi_write(32'h4, 32'h12345678, 4'b0101, resp);
    axi_read(32'h4, rdata, rresp);
    check_eq("t2_strb_rdata", rdata, 32'hFF34FF78);
    check_eq("t2_pulse_cnt", 32'(pulse_cnt[1] - p1_before), 32'd2);
    axi_write(32'h4, 32'h00000000, 4'b0000, resp);
    check_eq("t2_strb0_reg", reg_word(1), 32'hFF34FF78);
    check_eq("t2_strb0_pulse", 32'(pulse_cnt[1] - p1_before), 32'd3);
    check_eq("t2_reg0_kept", reg_word(0), 32'h0101FFFF);

    // Test 3: W three cycles ahead of AW, then same-cycle AW/W
    wr_lead(32'h8, 32'hA5A55A5A, 3);
    wr_lead(32'hC, 32'h5A5AA5A5, 0);

    // Test 4: back-pressured B; a second write must wait for the B handshake
    wr_issue(32'hC, 32'h11112222, 4'hF);
    tick();
    tick();
    S_AXI_AWADDR = 32'hC; S_AXI_WDATA = 32'h33334444; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_bvalid_hold", {31'd0, S_AXI_BVALID}, 32'd1);
      check_eq("t4_bresp_hold", {30'd0, S_AXI_BRESP}, 32'd0);
      check_eq("t4_readys_low", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
      tick();
    end
    check_eq("t4_reg_first", reg_word(3), 32'h11112222);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check_eq("t4_bvalid_drop", {31'd0, S_AXI_BVALID}, 32'd0);
    check_eq("t4_readys_back", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    wr_resp(resp);
    check_eq("t4_reg_second", reg_word(3), 32'h33334444);

    // Test 5: out-of-range address 0x10
    axi_write(32'h10, 32'hCAFEF00D, 4'hF, resp);
    axi_read(32'h10, rdata, rresp);
`ifdef HAST_AXI_LITE_ADDR_CHECK_EN
    check_eq("t5_bresp", {30'd0, resp}, 32'd2);
    check_eq("t5_rresp", {30'd0, rresp}, 32'd2);
    check_eq("t5_rdata", rdata, 32'd0);
    check_eq("t5_reg0", reg_word(0), 32'h0101FFFF);
`else
    check_eq("t5_bresp", {30'd0, resp}, 32'd0);
    check_eq("t5_rresp", {30'd0, rresp}, 32'd0);
    check_eq("t5_rdata", rdata, 32'hCAFEF00D);
    check_eq("t5_reg0", reg_word(0), 32'hCAFEF00D);
`endif
    check_eq("t5_reg1", reg_word(1), 32'hFF34FF78);

    // Test 6: reset with BVALID and RVALID pending
    wr_issue(32'h8, 32'h77778888, 4'hF);
    S_AXI_ARADDR = 32'h0;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    tick();
    check_eq("t6_pending", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd3);
    ARESET = 1'b1;
    tick();
    check_eq("t6_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
    check_eq("t6_regs", {31'd0, (reg_q != 128'd0)}, 32'd0);
    check_eq("t6_readys", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
    ARESET = 1'b0;
    tick();
    check_eq("t6_readys_back", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
    check_eq("t6_no_commit", {31'd0, (reg_q != 128'd0)}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
